// File: rtl/irq_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : irq_arb_pkg                                                     |
// | Purpose  : register map, FSM states and ID-width helper for irq_arbiter    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package irq_arb_pkg;

  localparam logic [3:0] PENDING_OFS  = 4'h0;
  localparam logic [3:0] ENABLE_OFS   = 4'h4;
  localparam logic [3:0] CLAIM_OFS    = 4'h8;
  localparam logic [3:0] COMPLETE_OFS = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } arb_state_e;

  // Bits needed to hold values 0..value-1; used with NUM_SRC+1 so id+1 fits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Interface : irq_arbiter_if                                                 |
// | Purpose   : APB slave bus bundle for the interrupt arbiter register block  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface irq_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );

endinterface

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// +----------------------------------------------------------------------------+
// | Module   : irq_prio_enc                                                    |
// | Purpose  : fixed-priority encoder, lowest index wins; reports id+1 (0=none)|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_prio_enc #(
  parameter int NUM_SRC  = 8,
  parameter int ID_WIDTH = irq_arb_pkg::clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0]  i_req,
  output logic                o_valid,
  output logic [ID_WIDTH-1:0] o_id
);

  // Scanning downward lets the lowest set index overwrite higher ones.
  always_comb begin
    o_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = ID_WIDTH'(i + 1);
    end
  end

  assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/irq_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : irq_arbiter                                                     |
// | Purpose  : APB interrupt arbiter with pending/enable/claim/complete regs   |
// |            Optional macro IRQ_EDGE_EN selects rising-edge source capture.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SRC    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000
) (
  input  logic               pclk,
  input  logic               presetn,
  irq_arbiter_if.slave       apb,
  input  logic [NUM_SRC-1:1] irq_src,
  input  logic               apb_perr,
  output logic               cpu_interrupt
);

  localparam int IDW = clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0]    r_pending;
  logic [NUM_SRC-1:0]    r_enable;
  logic [IDW-1:0]        r_insvc;
  arb_state_e            r_state;
  logic                  r_pready;
  logic                  r_perr;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic [NUM_SRC-1:0]    w_src;
  logic [NUM_SRC-1:0]    w_set;
  logic [NUM_SRC-1:0]    w_clr;
  logic                  w_valid;
  logic [IDW-1:0]        w_win_id;
  logic                  w_access;
  logic                  w_hit;
  logic [3:0]            w_ofs;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_cmpl_ok;
  logic                  w_en_wr;
  logic                  w_complete;
  logic                  w_claim;
  logic                  w_unused_pstb;

  assign w_src         = {irq_src, apb_perr};
  assign w_access      = apb.psel & apb.penable & ~r_pready;
  assign w_hit         = (apb.paddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) &&
                         (apb.paddr[1:0] == 2'b00);
  assign w_ofs         = apb.paddr[3:0];
  assign w_unused_pstb = ^apb.pstb;

  irq_prio_enc #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (IDW)
  ) u_prio_enc (
    .i_req   (r_pending & r_enable),
    .o_valid (w_valid),
    .o_id    (w_win_id)
  );

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] r_src_d;
  logic [NUM_SRC-1:0] r_edge;

  // Edge pulse is registered, so pending lags the source by one extra cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_src_d <= '0;
      r_edge  <= '0;
    end else begin
      r_src_d <= w_src;
      r_edge  <= w_src & ~r_src_d;
    end
  end

  assign w_set = r_edge;
`else
  assign w_set = w_src;
`endif

  assign w_cmpl_ok = (r_state == SERVICE) && (apb.pdata == DATA_WIDTH'(r_insvc));

  always_comb begin
    w_err   = 1'b0;
    w_rdata = '0;
    if (!w_hit) begin
      w_err = 1'b1;
    end else begin
      case (w_ofs)
        PENDING_OFS: begin
          w_err   = apb.pwrite;
          w_rdata = DATA_WIDTH'(r_pending);
        end
        ENABLE_OFS: w_rdata = DATA_WIDTH'(r_enable);
        CLAIM_OFS: begin
          w_err = apb.pwrite;
          if (r_state == ASSERT) w_rdata = DATA_WIDTH'(w_win_id);
        end
        COMPLETE_OFS: w_err = ~apb.pwrite | ~w_cmpl_ok;
        default:      w_err = 1'b1;
      endcase
    end
  end

  assign w_en_wr    = w_access & apb.pwrite & ~w_err & (w_ofs == ENABLE_OFS);
  assign w_complete = w_access & apb.pwrite & ~w_err & (w_ofs == COMPLETE_OFS);
  // A CLAIM read only claims while requesting and a winner still exists.
  assign w_claim    = w_access & ~apb.pwrite & ~w_err & (w_ofs == CLAIM_OFS) &
                      (r_state == ASSERT) & w_valid;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win_id == IDW'(i + 1)) w_clr[i] = w_claim;
    end
  end

  // Set is OR-ed after the clear so a simultaneous new request survives.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_en_wr) r_enable <= apb.pdata[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state  <= IDLE;
      r_insvc  <= '0;
      r_irq    <= 1'b0;
      r_pready <= 1'b0;
      r_perr   <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_pready <= w_access;
      r_perr   <= w_access & w_err;
      r_prdata <= (w_access & ~apb.pwrite & ~w_err) ? w_rdata : '0;
      r_irq    <= (r_state == ASSERT);
      case (r_state)
        IDLE: begin
          if (w_valid) r_state <= ASSERT;
        end
        ASSERT: begin
          if (w_claim) begin
            r_state <= SERVICE;
            r_insvc <= w_win_id;
          end else if (!w_valid) begin
            r_state <= IDLE;
          end
        end
        SERVICE: begin
          if (w_complete) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign apb.prdata    = r_prdata;
  assign apb.pready    = r_pready;
  assign apb.perr      = r_perr;
  assign cpu_interrupt = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_irq_arbiter                                                  |
// | Purpose  : directed bench for irq_arbiter with a cycle-level reference     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_irq_arbiter;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] OFS_PEND = 32'h0;
  localparam logic [31:0] OFS_EN   = 32'h4;
  localparam logic [31:0] OFS_CLM  = 32'h8;
  localparam logic [31:0] OFS_CMP  = 32'hC;

  logic            pclk    = 1'b0;
  logic            presetn = 1'b0;
  logic [NSRC-1:1] irq_src;
  logic            apb_perr;
  logic            cpu_interrupt;

  irq_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  irq_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_SRC    (NSRC),
    .BASE_ADDR  (BASE)
  ) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .apb           (bus.slave),
    .irq_src       (irq_src),
    .apb_perr      (apb_perr),
    .cpu_interrupt (cpu_interrupt)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: phase 0 = quiet, 1 = requesting the CPU, 2 = CPU servicing.
  bit          m_pend [NSRC];
  bit          m_prev [NSRC];
  bit          m_edge [NSRC];
  logic [31:0] m_en    = 0;
  int          m_phase = 0;
  int          m_insvc = 0;
  bit          m_irq   = 0;
  bit          m_rdy   = 0;
  bit          m_err   = 0;
  logic [31:0] m_rdata = 0;

  function automatic int m_winner();
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_pend_word();
    logic [31:0] v = 0;
    for (int i = 0; i < NSRC; i++) if (m_pend[i]) v += (32'd1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 0; m_prev[i] = 0; m_edge[i] = 0;
    end
    m_en = 0; m_phase = 0; m_insvc = 0; m_irq = 0; m_rdy = 0; m_err = 0; m_rdata = 0;
  endtask

  task automatic model_step();
    bit acc, hit, bad, claim, done, src;
    int w, ofs;
    logic [31:0] rd;
    acc = bus.psel && bus.penable && !m_rdy;
    w   = m_winner();
    hit = ((bus.paddr >> 4) == (BASE >> 4)) && (bus.paddr % 4 == 0);
    ofs = int'(bus.paddr % 16);
    bad = 1; rd = 0;
    if (hit) begin
      case (ofs)
        0:  begin bad = bus.pwrite; rd = m_pend_word(); end
        4:  begin bad = 0; rd = m_en; end
        8:  begin bad = bus.pwrite; rd = (m_phase == 1) ? w : 0; end
        12: bad = !bus.pwrite || m_phase != 2 || bus.pdata != m_insvc;
        default: bad = 1;
      endcase
    end
    if (bus.pwrite || bad) rd = 0;
    claim = acc && !bus.pwrite && !bad && ofs == 8 && m_phase == 1 && w != 0;
    done  = acc && bus.pwrite && !bad && ofs == 12;
    m_irq   = (m_phase == 1);
    m_rdy   = acc;
    m_err   = acc && bad;
    m_rdata = acc ? rd : 0;
    case (m_phase)
      0: if (w != 0) m_phase = 1;
      1: if (claim) begin m_phase = 2; m_insvc = w; end
         else if (w == 0) m_phase = 0;
      default: if (done) m_phase = 0;
    endcase
    if (acc && bus.pwrite && !bad && ofs == 4) m_en = bus.pdata & ((32'd1 << NSRC) - 1);
    for (int i = 0; i < NSRC; i++) begin
      src = (i == 0) ? apb_perr : irq_src[i];
      if (claim && w == i + 1) m_pend[i] = 0;
`ifdef IRQ_EDGE_EN
      if (m_edge[i]) m_pend[i] = 1;
      m_edge[i] = src && !m_prev[i];
      m_prev[i] = src;
`else
      if (src) m_pend[i] = 1;
`endif
    end
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) model_reset();
    else          model_step();
  end

  always @(negedge pclk) begin
    check("cpu_interrupt", {31'd0, cpu_interrupt}, {31'd0, m_irq});
    check("pready", {31'd0, bus.pready}, {31'd0, m_rdy});
    check("perr", {31'd0, bus.perr}, {31'd0, m_err});
    check("prdata", bus.prdata, m_rdata);
  end

  task automatic apb_xfer(input bit wr, input logic [31:0] ofs, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(negedge pclk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = BASE + ofs; bus.pdata = wdata;
    @(negedge pclk);
    bus.penable = 1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!bus.pready && n < 4);
    check("pready_within_bound", {31'd0, bus.pready}, 32'd1);
    rdata = bus.prdata;
    err   = bus.perr;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic wr(input string name, input logic [31:0] ofs, input logic [31:0] d, input bit exp_err);
    logic [31:0] r; logic e;
    apb_xfer(1'b1, ofs, d, r, e);
    check({name, "_perr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic rd(input string name, input logic [31:0] ofs, input logic [31:0] exp, input bit exp_err);
    logic [31:0] r; logic e;
    apb_xfer(1'b0, ofs, 32'd0, r, e);
    check({name, "_data"}, r, exp);
    check({name, "_perr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    @(negedge pclk);
    irq_src = m[NSRC-1:1]; apb_perr = m[0];
    @(negedge pclk);
    irq_src = '0; apb_perr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pdata = 0; bus.pstb = 4'hF;
    irq_src = '0; apb_perr = 0;
    idle(3);
    check("rst_cpu_interrupt", {31'd0, cpu_interrupt}, 32'd0);
    check("rst_pready", {31'd0, bus.pready}, 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    presetn = 1;
    rd("rst_pending", OFS_PEND, 32'h0, 0);
    rd("rst_enable", OFS_EN, 32'h0, 0);

    // Basic claim/complete of source 3
    wr("en_0c", OFS_EN, 32'h0C, 0);
    pulse(8'h08);
    idle(4);
    check("basic_irq_high", {31'd0, cpu_interrupt}, 32'd1);
    rd("basic_pending", OFS_PEND, 32'h08, 0);
    rd("basic_claim", OFS_CLM, 32'd4, 0);
    idle(2);
    check("basic_irq_low_in_service", {31'd0, cpu_interrupt}, 32'd0);
    rd("basic_pending_cleared", OFS_PEND, 32'h0, 0);
    wr("basic_complete", OFS_CMP, 32'd4, 0);
    idle(3);

    // Priority between sources 2 and 5
    wr("en_ff", OFS_EN, 32'hFF, 0);
    pulse(8'h24);
    idle(4);
    rd("prio_claim_first", OFS_CLM, 32'd3, 0);
    wr("prio_complete_first", OFS_CMP, 32'd3, 0);
    idle(4);
    check("prio_irq_reassert", {31'd0, cpu_interrupt}, 32'd1);
    rd("prio_claim_second", OFS_CLM, 32'd6, 0);
    wr("prio_complete_second", OFS_CMP, 32'd6, 0);
    idle(3);

    // Error responses
    wr("err_wr_pending", OFS_PEND, 32'hFF, 1);
    rd("err_pending_unchanged", OFS_PEND, 32'h0, 0);
    wr("err_complete_idle", OFS_CMP, 32'd1, 1);
    rd("claim_outside_assert", OFS_CLM, 32'd0, 0);
    pulse(8'h04);
    idle(4);
    rd("err_claim", OFS_CLM, 32'd3, 0);
    wr("err_complete_wrong_id", OFS_CMP, 32'd7, 1);
    rd("claim_in_service", OFS_CLM, 32'd0, 0);
    check("err_irq_still_low", {31'd0, cpu_interrupt}, 32'd0);
    wr("err_complete_right_id", OFS_CMP, 32'd3, 0);
    rd("err_undecoded_10", 32'h10, 32'd0, 1);
    rd("err_rd_complete", OFS_CMP, 32'd0, 1);
    wr("err_wr_claim", OFS_CLM, 32'd1, 1);
    idle(2);

    // ENABLE width clamp and masking out an asserted request
    wr("en_all_ones", OFS_EN, 32'hFFFF_FFFF, 0);
    rd("en_clamped", OFS_EN, 32'hFF, 0);
    pulse(8'h10);
    idle(4);
    check("mask_irq_high", {31'd0, cpu_interrupt}, 32'd1);
    wr("mask_en_zero", OFS_EN, 32'h0, 0);
    idle(3);
    check("mask_irq_dropped", {31'd0, cpu_interrupt}, 32'd0);
    rd("mask_pending_kept", OFS_PEND, 32'h10, 0);
    wr("mask_en_10", OFS_EN, 32'h10, 0);
    idle(4);
    rd("mask_claim", OFS_CLM, 32'd5, 0);
    wr("mask_complete", OFS_CMP, 32'd5, 0);

    // Bus error source 0
    wr("en_01", OFS_EN, 32'h01, 0);
    pulse(8'h01);
    idle(4);
    check("buserr_irq_high", {31'd0, cpu_interrupt}, 32'd1);
    rd("buserr_claim", OFS_CLM, 32'd1, 0);
    wr("buserr_complete", OFS_CMP, 32'd1, 0);
    idle(2);

    // Held-high source 1: level re-pends, edge sets once
    wr("en_02", OFS_EN, 32'h02, 0);
    @(negedge pclk);
    irq_src[1] = 1;
    idle(4);
    rd("hold_claim", OFS_CLM, 32'd2, 0);
    wr("hold_complete", OFS_CMP, 32'd2, 0);
    idle(4);
`ifdef IRQ_EDGE_EN
    rd("hold_pending_edge", OFS_PEND, 32'h0, 0);
    check("hold_irq_edge", {31'd0, cpu_interrupt}, 32'd0);
    irq_src[1] = 0;
`else
    rd("hold_pending_level", OFS_PEND, 32'h02, 0);
    check("hold_irq_level", {31'd0, cpu_interrupt}, 32'd1);
    irq_src[1] = 0;
    rd("hold_claim_again", OFS_CLM, 32'd2, 0);
    wr("hold_complete_again", OFS_CMP, 32'd2, 0);
    rd("hold_pending_final", OFS_PEND, 32'h0, 0);
`endif
    idle(2);

    // Asynchronous reset in the middle of a claim, leaving SERVICE
    wr("rst_en_08", OFS_EN, 32'h08, 0);
    pulse(8'h08);
    idle(4);
    @(negedge pclk);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = BASE + OFS_CLM;
    @(negedge pclk);
    bus.penable = 1;
    @(posedge pclk);
    #2;
    check("pre_rst_prdata", bus.prdata, 32'd4);
    check("pre_rst_irq", {31'd0, cpu_interrupt}, 32'd1);
    presetn = 0;
    #1;
    check("async_rst_prdata", bus.prdata, 32'd0);
    check("async_rst_pready", {31'd0, bus.pready}, 32'd0);
    check("async_rst_perr", {31'd0, bus.perr}, 32'd0);
    check("async_rst_irq", {31'd0, cpu_interrupt}, 32'd0);
    bus.psel = 0; bus.penable = 0;
    idle(2);
    presetn = 1;
    rd("post_rst_pending", OFS_PEND, 32'h0, 0);
    rd("post_rst_enable", OFS_EN, 32'h0, 0);
    rd("post_rst_claim", OFS_CLM, 32'd0, 0);
    wr("post_rst_complete", OFS_CMP, 32'd4, 1);
    idle(3);
    check("post_rst_irq", {31'd0, cpu_interrupt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
